coarse_seq: RTL and testbench

- Sequences the CDU coarse resolver switch network.
- Decodes the read counter into the 12 coarse switch drives _DC1.._DC12.
- Waits for the summing amp and Schmitt triggers to settle, samples them, then steps the read counter up or down by one coarse increment until the coarse error nulls.
- Sits between the read counter consumers (fine loop, AGC interface) and the analog coarse module.

---
 rtl/coarse_seq_if.sv | 26 ++
 rtl/coarse_seq.sv | 138 +++++++++++++
 tb/tb_coarse_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/coarse_seq_if.sv
// Coarse resolver sequencer bus: loop controls, analog trigger inputs,
// switch drives and read-counter outputs.
interface coarse_seq_if;
  logic        en;
  logic        load;
  logic [14:0] load_val;
  logic        _TLC1H;
  logic        _TLC2H;
  logic        _ADHI;
  logic [11:0] _DC;
  logic [14:0] read_cnt;
  logic        up_pls;
  logic        dn_pls;
  logic        coarse_null;
  logic        amb_err;

  modport master (
    output en, load, load_val, _TLC1H, _TLC2H, _ADHI,
    input  _DC, read_cnt, up_pls, dn_pls, coarse_null, amb_err
  );

  modport slave (
    input  en, load, load_val, _TLC1H, _TLC2H, _ADHI,
    output _DC, read_cnt, up_pls, dn_pls, coarse_null, amb_err
  );
endinterface

// File: rtl/coarse_seq.sv
// CDU coarse loop sequencer: drives the coarse switch network from the read
// counter, samples the error triggers after settling and steps toward null.
module coarse_seq #(
  parameter int SETTLE_CYCLES = 8,
  parameter int STEP_LOG2     = 6,
  parameter int NULL_CNT      = 3
) (
  input  logic         clk,
  input  logic         rst,
  coarse_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, STEP} state_e;

  localparam logic [14:0] STEP_VAL = 15'(1 << STEP_LOG2);
  localparam logic [7:0]  TMR_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  NULL_THR = 4'(NULL_CNT);

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [11:0] dc_q, dc_d;
  logic [7:0]  tmr_q, tmr_d;
  logic        dir_up_q, dir_up_d;
  logic [3:0]  nul_q, nul_d;
  logic        amb_q, amb_d;
  logic        up_pls, dn_pls, coarse_null;

  // Octant picks the sin/cos switch pair; bits 11:8 drive DC9..DC12.
  function automatic logic [11:0] dc_decode(input logic [14:0] cnt);
    logic [7:0] oct;
    case (cnt[14:12])
      3'd0:    oct = 8'h14;
      3'd1:    oct = 8'h28;
      3'd2:    oct = 8'h22;
      3'd3:    oct = 8'h11;
      3'd4:    oct = 8'h41;
      3'd5:    oct = 8'h82;
      3'd6:    oct = 8'h88;
      default: oct = 8'h44;
    endcase
    return {cnt[8], cnt[9], cnt[10], cnt[11], oct};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dc_q     <= '0;
      tmr_q    <= '0;
      dir_up_q <= 1'b0;
      nul_q    <= '0;
      amb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dc_q     <= dc_d;
      tmr_q    <= tmr_d;
      dir_up_q <= dir_up_d;
      nul_q    <= nul_d;
      amb_q    <= amb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dc_d     = dc_q;
    tmr_d    = tmr_q;
    dir_up_d = dir_up_q;
    nul_d    = nul_q;
    amb_d    = amb_q;
    if (bus.load) begin
      cnt_d   = bus.load_val;
      nul_d   = '0;
      state_d = bus.en ? DRIVE : IDLE;
    end else if (!bus.en) begin
      // A step already in flight still lands its count.
      if (state_q == STEP)
        cnt_d = dir_up_q ? cnt_q + STEP_VAL : cnt_q - STEP_VAL;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   state_d = DRIVE;
        DRIVE: begin
          dc_d    = dc_decode(cnt_q);
          tmr_d   = '0;
          state_d = SETTLE;
        end
        SETTLE: begin
          if (tmr_q == TMR_LAST) state_d = SAMPLE;
          else                   tmr_d   = tmr_q + 8'd1;
        end
        SAMPLE: begin
          if (bus._TLC1H && bus._TLC2H) begin
            amb_d   = 1'b1;
            nul_d   = '0;
            state_d = DRIVE;
          end else if (bus._TLC1H || bus._TLC2H || !bus._ADHI) begin
            // False null near 180 deg is pushed off with an up step.
            dir_up_d = !bus._TLC2H || bus._TLC1H;
            nul_d    = '0;
            state_d  = STEP;
          end else begin
            if (nul_q != 4'hF) nul_d = nul_q + 4'd1;
            state_d = DRIVE;
          end
        end
        STEP: begin
          cnt_d   = dir_up_q ? cnt_q + STEP_VAL : cnt_q - STEP_VAL;
          state_d = DRIVE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == IDLE) begin
      dc_d  = '0;
      nul_d = '0;
    end
  end

  always_comb begin
    up_pls      = 1'b0;
    dn_pls      = 1'b0;
    coarse_null = (nul_q >= NULL_THR);
    if (state_q == STEP && !bus.load) begin
      up_pls = dir_up_q;
      dn_pls = !dir_up_q;
    end
  end

  assign bus._DC         = dc_q;
  assign bus.read_cnt    = cnt_q;
  assign bus.up_pls      = up_pls;
  assign bus.dn_pls      = dn_pls;
  assign bus.coarse_null = coarse_null;
  assign bus.amb_err     = amb_q;

endmodule

// File: tb/tb_coarse_seq.sv
// Directed bench for coarse_seq with default parameters (settle 8, step 0x40, null 3).
module tb_coarse_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  coarse_seq_if bus();

  coarse_seq #(.SETTLE_CYCLES(8), .STEP_LOG2(6), .NULL_CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From DRIVE: 9 edges to SAMPLE, 10 to STEP, 11 to the next DRIVE.
  task automatic period(input bit up, input logic [14:0] exp_cnt, input string tag);
    repeat (9) tick();
    chk({tag, " quiet"}, {30'd0, bus.up_pls, bus.dn_pls}, 32'd0);
    tick();
    chk({tag, " pulse"}, {30'd0, bus.up_pls, bus.dn_pls}, up ? 32'd2 : 32'd1);
    tick();
    chk({tag, " cnt"}, {17'd0, bus.read_cnt}, {17'd0, exp_cnt});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus._TLC1H = 1'b0;
    bus._TLC2H = 1'b0;
    bus._ADHI = 1'b1;
    tick();
    tick();
    chk("rst dc",   {20'd0, bus._DC}, 32'd0);
    chk("rst cnt",  {17'd0, bus.read_cnt}, 32'd0);
    chk("rst up",   {31'd0, bus.up_pls}, 32'd0);
    chk("rst dn",   {31'd0, bus.dn_pls}, 32'd0);
    chk("rst null", {31'd0, bus.coarse_null}, 32'd0);
    chk("rst amb",  {31'd0, bus.amb_err}, 32'd0);
    rst = 1'b0;

    // Load 0x1234 while enabling; the following DRIVE decodes it.
    bus.en = 1'b1;
    bus.load = 1'b1;
    bus.load_val = 15'h1234;
    tick();
    chk("load cnt", {17'd0, bus.read_cnt}, 32'h1234);
    bus.load = 1'b0;
    tick();
    tick();
    chk("dc 1234", {20'd0, bus._DC}, 32'h428);

    // Reload zero from IDLE, then walk the up-step timing edge by edge.
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.load_val = 15'h0000;
    tick();
    bus.load = 1'b0;
    tick();
    chk("idle dc", {20'd0, bus._DC}, 32'd0);
    bus.en = 1'b1;
    bus._TLC1H = 1'b1;
    tick();
    chk("drive dc", {20'd0, bus._DC}, 32'd0);
    tick();
    chk("dc 0000", {20'd0, bus._DC}, 32'h014);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("up early", {31'd0, bus.up_pls}, 32'd0);
    end
    tick();
    chk("up cyc11", {30'd0, bus.up_pls, bus.dn_pls}, 32'd2);
    tick();
    chk("up after", {31'd0, bus.up_pls}, 32'd0);
    chk("cnt 0040", {17'd0, bus.read_cnt}, 32'h0040);
    period(1'b1, 15'h0080, "up2");

    // Down steps through zero and wrap.
    bus._TLC1H = 1'b0;
    bus._TLC2H = 1'b1;
    period(1'b0, 15'h0040, "dn1");
    period(1'b0, 15'h0000, "dn2");
    period(1'b0, 15'h7FC0, "dnwrap");
    tick();
    chk("dc 7fc0", {20'd0, bus._DC}, 32'hF44);
    bus._TLC2H = 1'b0;

    // Three null samples assert coarse_null; a real error clears it.
    repeat (8) tick();
    tick();
    chk("null1", {31'd0, bus.coarse_null}, 32'd0);
    repeat (10) tick();
    chk("null2", {31'd0, bus.coarse_null}, 32'd0);
    repeat (9) tick();
    chk("null3 pre", {31'd0, bus.coarse_null}, 32'd0);
    tick();
    chk("null3", {31'd0, bus.coarse_null}, 32'd1);
    chk("null cnt", {17'd0, bus.read_cnt}, 32'h7FC0);
    bus._TLC1H = 1'b1;
    repeat (9) tick();
    chk("null smp", {31'd0, bus.coarse_null}, 32'd1);
    tick();
    chk("null clr", {31'd0, bus.coarse_null}, 32'd0);
    chk("null up",  {30'd0, bus.up_pls, bus.dn_pls}, 32'd2);
    tick();
    chk("upwrap", {17'd0, bus.read_cnt}, 32'h0000);

    // Both triggers: ambiguity, no step.
    bus._TLC2H = 1'b1;
    repeat (9) tick();
    chk("amb smp", {31'd0, bus.amb_err}, 32'd0);
    tick();
    chk("amb set",   {31'd0, bus.amb_err}, 32'd1);
    chk("amb nopls", {30'd0, bus.up_pls, bus.dn_pls}, 32'd0);
    chk("amb cnt",   {17'd0, bus.read_cnt}, 32'h0000);
    bus._TLC1H = 1'b0;
    bus._TLC2H = 1'b0;
    bus._ADHI = 1'b0;
    period(1'b1, 15'h0040, "false1");
    period(1'b1, 15'h0080, "false2");
    chk("amb sticky", {31'd0, bus.amb_err}, 32'd1);

    // Load mid-SETTLE.
    bus._ADHI = 1'b1;
    repeat (4) tick();
    bus.load = 1'b1;
    bus.load_val = 15'h7000;
    tick();
    chk("ld pls", {30'd0, bus.up_pls, bus.dn_pls}, 32'd0);
    chk("ld cnt", {17'd0, bus.read_cnt}, 32'h7000);
    bus.load = 1'b0;
    tick();
    chk("dc 7000", {20'd0, bus._DC}, 32'h044);

    // Drop en mid-SETTLE.
    tick();
    tick();
    bus.en = 1'b0;
    tick();
    chk("en off dc",  {20'd0, bus._DC}, 32'd0);
    chk("en off cnt", {17'd0, bus.read_cnt}, 32'h7000);

    // Async reset while a step pulse is high.
    bus.en = 1'b1;
    bus._TLC1H = 1'b1;
    tick();
    repeat (10) tick();
    chk("pre rst up", {31'd0, bus.up_pls}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst up",   {31'd0, bus.up_pls}, 32'd0);
    chk("arst dn",   {31'd0, bus.dn_pls}, 32'd0);
    chk("arst dc",   {20'd0, bus._DC}, 32'd0);
    chk("arst cnt",  {17'd0, bus.read_cnt}, 32'd0);
    chk("arst null", {31'd0, bus.coarse_null}, 32'd0);
    chk("arst amb",  {31'd0, bus.amb_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
